// File: rtl/mvm_host_driver_if.sv
// mvm_host_driver_if: operand-memory, MVM-core and result-stream signals of the host driver
interface mvm_host_driver_if #(
    parameter int K  = 32,
    parameter int B  = 8,
    parameter int AW = $clog2(K*K+K)
);
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [B-1:0]  mem_rdata;
    logic          mvm_loadMatrix;
    logic          mvm_loadVector;
    logic          mvm_start;
    logic [B-1:0]  mvm_data_in;
    logic          mvm_done;
    logic [2*B-1:0] mvm_data_out;
    logic          res_valid;
    logic          res_ready;
    logic [2*B-1:0] res_data;
    logic          res_last;
    modport master (
        output mem_en, mem_addr, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in,
               res_valid, res_data, res_last,
        input  mem_rdata, mvm_done, mvm_data_out, res_ready
    );
    modport slave (
        input  mem_en, mem_addr, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in,
               res_valid, res_data, res_last,
        output mem_rdata, mvm_done, mvm_data_out, res_ready
    );
endinterface

// File: rtl/mvm_host_driver.sv
// mvm_host_driver: streams matrix and vector from operand memory into the MVM core,
// then buffers its K results onto a valid/ready stream.
module mvm_host_driver #(
    parameter int K         = 32,
    parameter int B         = 8,
    parameter int AW        = $clog2(K*K+K),
    parameter int VEC_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    output logic              busy_o,
    mvm_host_driver_if.master bus
);
    localparam int N1    = VEC_FIRST ? K : K*K;
    localparam int N2    = VEC_FIRST ? K*K : K;
    localparam int BASE1 = VEC_FIRST ? K*K : 0;
    localparam int BASE2 = VEC_FIRST ? 0 : K*K;
    localparam int CW    = $clog2(K*K+1);
    localparam int PW    = $clog2(K+1);
    localparam int IW    = K > 1 ? $clog2(K) : 1;

    typedef enum logic [3:0] {
        IDLE, LD1_CMD, LD1, GAP1, LD2_CMD, LD2, GAP2, START, WAIT_DONE, CAPTURE, DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           mem_en_q, mem_en_d, ldm_q, ldm_d, ldv_q, ldv_d, start_q, start_d;
    logic           valid, fire, last, cmd, seg1;
    logic [2*B-1:0] res_buf_q [K];

    assign valid = rd_q < wr_q;
    assign last  = rd_q == PW'(K-1);
    assign fire  = valid & bus.res_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = fire ? rd_q + PW'(1) : rd_q;
        case (state_q)
            IDLE:      state_d = go_i ? LD1_CMD : IDLE;
            LD1_CMD:   begin state_d = LD1; cnt_d = '0; end
            LD1:       begin cnt_d = cnt_q + CW'(1); state_d = cnt_q == CW'(N1-1) ? GAP1 : LD1; end
            GAP1:      state_d = LD2_CMD;
            LD2_CMD:   begin state_d = LD2; cnt_d = '0; end
            LD2:       begin cnt_d = cnt_q + CW'(1); state_d = cnt_q == CW'(N2-1) ? GAP2 : LD2; end
            GAP2:      state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: state_d = bus.mvm_done ? CAPTURE : WAIT_DONE;
            CAPTURE:   begin wr_d = wr_q + PW'(1); state_d = wr_q == PW'(K-1) ? DRAIN : CAPTURE; end
            DRAIN:     if (fire && last) begin state_d = IDLE; wr_d = '0; rd_d = '0; end
            default:   state_d = IDLE;
        endcase
        // memory and load strobes are registered, so they are decoded from the next state
        cmd      = state_d == LD1_CMD || state_d == LD2_CMD;
        seg1     = state_d == LD1_CMD || state_d == LD1;
        mem_en_d = cmd || (state_d == LD1 && cnt_d < CW'(N1-1)) || (state_d == LD2 && cnt_d < CW'(N2-1));
        addr_d   = !mem_en_d ? '0 : AW'(seg1 ? BASE1 : BASE2) + (cmd ? '0 : AW'(cnt_d) + AW'(1));
        ldm_d    = VEC_FIRST ? state_d == LD2_CMD : state_d == LD1_CMD;
        ldv_d    = VEC_FIRST ? state_d == LD1_CMD : state_d == LD2_CMD;
        start_d  = state_d == START;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            mem_en_q <= 1'b0;
            ldm_q    <= 1'b0;
            ldv_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            mem_en_q <= mem_en_d;
            ldm_q    <= ldm_d;
            ldv_q    <= ldv_d;
            start_q  <= start_d;
        end
    end

    always_ff @(posedge clk)
        if (state_q == CAPTURE) res_buf_q[wr_q[IW-1:0]] <= bus.mvm_data_out;

    assign busy_o             = state_q != IDLE;
    assign bus.mem_en         = mem_en_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mvm_loadMatrix = ldm_q;
    assign bus.mvm_loadVector = ldv_q;
    assign bus.mvm_start      = start_q;
    assign bus.mvm_data_in    = (state_q == LD1 || state_q == LD2) ? bus.mem_rdata : '0;
    assign bus.res_valid      = valid;
    assign bus.res_data       = valid ? res_buf_q[rd_q[IW-1:0]] : '0;
    assign bus.res_last       = valid && last;
endmodule
